// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional misaligned-redirect trap: FETCH_MISALIGN_TRAP_EN.
package fetch_pkg;
   localparam int XLEN = 64;
   localparam int ILEN = 32;
   localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_BOOT,
      S_RUN,
      S_FLUSH
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
`ifdef FETCH_MISALIGN_TRAP_EN
      logic            misalign;
`endif
   } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched entries with flush and occupancy count.
// Head entry is presented combinationally from storage.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  fetch_entry_t             din,
   input  logic                     pop,
   input  logic                     flush,
   output fetch_entry_t             dout,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  rd;
   logic [AW-1:0]  wr;
   logic           do_push;
   logic           do_pop;

   assign do_push = push && (count != CW'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign dout    = mem[rd];

   // Storage is cleared on reset so the outputs read zero afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rd    <= '0;
         wr    <= '0;
         count <= '0;
      end else if (flush) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            mem[wr] <= din;
            wr      <= wr + 1'b1;
         end
         if (do_pop) rd <= rd + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues to instruction memory, queues responses.
// Optional misaligned-redirect trap: FETCH_MISALIGN_TRAP_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter int              QUEUE_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [XLEN-1:0] imem_addr,
   input  logic [ILEN-1:0] imem_instr,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [ILEN-1:0] out_instr
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic            out_misalign
`endif
);
   localparam int CW = $clog2(QUEUE_DEPTH) + 1;
   localparam logic [CW:0] QD = (CW+1)'(QUEUE_DEPTH);

   fetch_state_e    state;
   fetch_state_e    state_nx;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] req_pc;
   logic [XLEN-1:0] tgt_pc;
   logic            inflight;
   logic            deq;
   logic            issue;
   logic            capture;
   logic            push;
   logic            can_issue;
   logic [CW-1:0]   count;
   logic [CW:0]     occ;
   fetch_entry_t    push_d;
   fetch_entry_t    head;

   assign imem_addr = pc;
   assign out_valid = (count != '0);
   assign out_pc    = head.pc;
   assign out_instr = head.instr;
   assign deq       = out_valid && out_ready;

   // Credit: entries held plus the response in flight, minus this pop.
   assign occ     = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(deq);
   assign issue   = (state != S_BOOT) && !redirect_valid && can_issue
                    && (occ < QD);
   assign capture = inflight && (state == S_RUN) && !redirect_valid;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic mis_pend;
   logic halt;

   assign tgt_pc       = redirect_pc;
   assign can_issue    = !halt;
   assign push         = capture || (mis_pend && !redirect_valid);
   assign out_misalign = head.misalign;

   // A misaligned target yields one trap entry, then fetch parks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mis_pend <= 1'b0;
         halt     <= 1'b0;
      end else if (redirect_valid) begin
         mis_pend <= (redirect_pc[1:0] != 2'b00);
         halt     <= (redirect_pc[1:0] != 2'b00);
      end else begin
         mis_pend <= 1'b0;
      end
   end
`else
   assign tgt_pc    = redirect_pc & ~64'h3;
   assign can_issue = 1'b1;
   assign push      = capture;
`endif

   always_comb begin
      push_d       = '0;
      push_d.pc    = req_pc;
      push_d.instr = imem_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (mis_pend) begin
         push_d.pc       = pc;
         push_d.instr    = NOP_INSTR;
         push_d.misalign = 1'b1;
      end
`endif
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_BOOT:  state_nx = S_RUN;
         S_RUN:   state_nx = S_RUN;
         S_FLUSH: state_nx = S_RUN;
         default: state_nx = S_RUN;
      endcase
      if (redirect_valid) state_nx = S_FLUSH;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_BOOT;
         pc       <= RESET_PC;
         req_pc   <= '0;
         inflight <= 1'b0;
      end else begin
         state    <= state_nx;
         inflight <= issue;
         if (redirect_valid) begin
            pc <= tgt_pc;
         end else if (issue) begin
            pc     <= pc + 64'd4;
            req_pc <= pc;
         end
      end
   end

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (push_d),
      .pop   (deq),
      .flush (redirect_valid),
      .dout  (head),
      .count (count)
   );
endmodule
